// File: rtl/au_param_if.sv
// rtl/au_param_if.sv - request/response bundle between the controller and the arithmetic unit
interface au_param_if #(
  parameter int W = 24
);
  logic         start;
  logic [W-1:0] R;
  logic [W-1:0] S;
  logic [W-1:0] I;
  logic         imm_sel;
  logic [1:0]   ctl_d;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         ovf;
  logic         dz;

  modport master (
    output start, R, S, I, imm_sel, ctl_d,
    input  result, done, busy, ovf, dz
  );

  modport slave (
    input  start, R, S, I, imm_sel, ctl_d,
    output result, done, busy, ovf, dz
  );
endinterface

// File: rtl/au_param.sv
// rtl/au_param.sv - sign-magnitude fixed-point add/sub/mul/div unit with iterative divider
module au_param #(
  parameter int W    = 24,
  parameter int FRAC = 14,
  parameter int SAT  = 1
) (
  input  logic      clk,
  input  logic      rst,
  au_param_if.slave bus
);
  localparam int M  = W - 1;          // magnitude bits
  localparam int N  = M + FRAC;       // divider iterations / dividend width
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SIMPLE, DIV, FIN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [M-1:0]   rem_q, rem_d;
  logic [N-1:0]   rq_q, rq_d;         // dividend shifts out the top, quotient shifts in the bottom
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   b_in;
  logic           sa, sb;
  logic [M-1:0]   ma, mb;
  logic [M:0]     sum;
  logic [2*M-1:0] prod, prod_sh;
  logic [M:0]     trial;
  logic [M-1:0]   trial_sub;
  logic           take;
  logic [N:0]     qx;
  logic           raw_sign, raw_ovf, raw_dz;
  logic [M-1:0]   raw_mag, fin_mag;

  // Arithmetic on the captured operands: raw result for the completing state, plus one divider step
  always_comb begin
    b_in      = bus.imm_sel ? bus.I : bus.S;
    sa        = a_q[W-1];
    ma        = a_q[M-1:0];
    mb        = b_q[M-1:0];
    sb        = b_q[W-1] ^ (op_q == 2'b01);
    sum       = {1'b0, ma} + {1'b0, mb};
    prod      = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
    prod_sh   = prod >> FRAC;
    trial     = {rem_q, rq_q[N-1]};
    take      = (trial >= {1'b0, mb});
    trial_sub = trial[M-1:0] - mb;
    qx        = {1'b0, rq_q};
    raw_sign  = 1'b0;
    raw_mag   = '0;
    raw_ovf   = 1'b0;
    raw_dz    = 1'b0;
    if (state_q == FIN) begin
      raw_sign = sa ^ sb;
      raw_mag  = rq_q[M-1:0];
      raw_ovf  = |(qx >> M);
    end else begin
      case (op_q)
        2'b10: begin
          raw_sign = sa ^ sb;
          raw_mag  = prod_sh[M-1:0];
          raw_ovf  = |(prod_sh >> M);
        end
        2'b11: begin
          // only a zero divisor reaches the simple path for DIV
          raw_sign = sa ^ sb;
          raw_mag  = '1;
          raw_ovf  = 1'b1;
          raw_dz   = 1'b1;
        end
        default: begin
          if (sa == sb) begin
            raw_sign = sa;
            raw_mag  = sum[M-1:0];
            raw_ovf  = sum[M];
          end else if (ma >= mb) begin
            raw_sign = sa;
            raw_mag  = ma - mb;
          end else begin
            raw_sign = sb;
            raw_mag  = mb - ma;
          end
        end
      endcase
    end
    fin_mag = (raw_ovf && (SAT != 0)) ? {M{1'b1}} : raw_mag;
  end

  // Next-state and register updates; start is refused during the done cycle
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    rem_d    = rem_q;
    rq_d     = rq_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          a_d   = bus.R;
          b_d   = b_in;
          op_d  = bus.ctl_d;
          ovf_d = 1'b0;
          dz_d  = 1'b0;
          rem_d = '0;
          rq_d  = N'(bus.R[M-1:0]) << FRAC;
          cnt_d = '0;
          state_d = (bus.ctl_d == 2'b11 && b_in[M-1:0] != '0) ? DIV : SIMPLE;
        end
      end
      SIMPLE, FIN: begin
        result_d = (fin_mag == '0) ? '0 : {raw_sign, fin_mag};
        ovf_d    = raw_ovf;
        dz_d     = raw_dz;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      DIV: begin
        rem_d = take ? trial_sub : trial[M-1:0];
        rq_d  = {rq_q[N-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      rem_q    <= '0;
      rq_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      rem_q    <= rem_d;
      rq_q     <= rq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.ovf    = ovf_q;
  assign bus.dz     = dz_q;
endmodule

// File: tb/tb_au_param.sv
// tb/tb_au_param.sv - directed and random checks of au_param against a signed-arithmetic model
module tb_au_param;
  localparam int W    = 24;
  localparam int FRAC = 14;
  localparam int N    = W - 1 + FRAC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  au_param_if #(.W(W)) if_s ();
  au_param_if #(.W(W)) if_w ();

  au_param #(.W(W), .FRAC(FRAC), .SAT(1)) u_sat (.clk(clk), .rst(rst), .bus(if_s.slave));
  au_param #(.W(W), .FRAC(FRAC), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(if_w.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic on the decoded values, then range handling
  function automatic logic [W+1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input bit sat);
    longint ma, mb, va, vb, r, mag, maxv;
    bit neg, ovf, dz;
    maxv = (longint'(1) << (W - 1)) - 1;
    ma = longint'(a[W-2:0]);
    mb = longint'(b[W-2:0]);
    neg = 1'b0; ovf = 1'b0; dz = 1'b0; mag = 0;
    case (op)
      2'b00, 2'b01: begin
        va  = a[W-1] ? -ma : ma;
        vb  = (b[W-1] ^ (op == 2'b01)) ? -mb : mb;
        r   = va + vb;
        neg = (r < 0);
        mag = neg ? -r : r;
      end
      2'b10: begin
        mag = (ma * mb) >> FRAC;
        neg = a[W-1] ^ b[W-1];
      end
      default: begin
        neg = a[W-1] ^ b[W-1];
        if (mb == 0) begin
          dz = 1'b1; ovf = 1'b1; mag = maxv;
        end else begin
          mag = (ma << FRAC) / mb;
        end
      end
    endcase
    if (mag > maxv) begin
      ovf = 1'b1;
      mag = sat ? maxv : (mag & maxv);
    end
    if (mag == 0) return {dz, ovf, {W{1'b0}}};
    return {dz, ovf, neg, mag[W-2:0]};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 3))
      0: ;
      1: v = {v[W-1], {(W-17){1'b0}}, v[15:0]};
      2: v = {v[W-1], {(W-1){1'b0}}};
      default: v = v | {1'b0, 5'b11111, {(W-6){1'b0}}};
    endcase
    return v;
  endfunction

  task automatic drive(input logic st, input logic [1:0] op, input logic [W-1:0] r,
                       input logic [W-1:0] s, input logic [W-1:0] i, input logic imm);
    if_s.start = st; if_s.ctl_d = op; if_s.R = r; if_s.S = s; if_s.I = i; if_s.imm_sel = imm;
    if_w.start = st; if_w.ctl_d = op; if_w.R = r; if_w.S = s; if_w.I = i; if_w.imm_sel = imm;
  endtask

  task automatic drive_junk(input logic st);
    drive(st, 2'($urandom), rnd_word(), rnd_word(), rnd_word(), 1'($urandom));
  endtask

  // One operation on both instances, called at posedge+1
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] r,
                        input logic [W-1:0] s, input logic [W-1:0] i, input logic imm,
                        input bit poke, input bit lit, input logic [W-1:0] lit_s,
                        input logic [W-1:0] lit_w);
    logic [W-1:0] b;
    logic [W+1:0] es, ew;
    int lat, exp_lat;
    b  = imm ? i : s;
    es = model(op, r, b, 1'b1);
    ew = model(op, r, b, 1'b0);
    exp_lat = (op == 2'b11 && b[W-2:0] != '0) ? N + 1 : 1;
    drive(1'b1, op, r, s, i, imm);
    @(posedge clk); #1;
    drive_junk(1'b0);
    chk({tag, " busy_after_start"}, 32'(if_s.busy), 32'd1);
    lat = 0;
    do begin
      if_s.start = poke && (lat == 5);
      if_w.start = if_s.start;
      @(posedge clk); #1;
      lat++;
    end while (!if_s.done && lat < 200);
    if_s.start = 1'b0; if_w.start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_at_done"}, 32'(if_s.busy), 32'd0);
    chk({tag, " wrap_done"}, 32'(if_w.done), 32'd1);
    chk({tag, " sat_result"}, 32'(if_s.result), 32'(es[W-1:0]));
    chk({tag, " sat_ovf"}, 32'(if_s.ovf), 32'(es[W]));
    chk({tag, " sat_dz"}, 32'(if_s.dz), 32'(es[W+1]));
    chk({tag, " wrap_result"}, 32'(if_w.result), 32'(ew[W-1:0]));
    chk({tag, " wrap_ovf"}, 32'(if_w.ovf), 32'(ew[W]));
    chk({tag, " wrap_dz"}, 32'(if_w.dz), 32'(ew[W+1]));
    if (lit) begin
      chk({tag, " sat_literal"}, 32'(if_s.result), 32'(lit_s));
      chk({tag, " wrap_literal"}, 32'(if_w.result), 32'(lit_w));
    end
    // a start coincident with done must not be accepted
    drive_junk(1'b1);
    @(posedge clk); #1;
    drive_junk(1'b0);
    chk({tag, " done_one_cycle"}, 32'(if_s.done), 32'd0);
    chk({tag, " start_on_done_ignored"}, 32'(if_s.busy | if_w.busy), 32'd0);
  endtask

  initial begin
    bit saw_done;
    drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", 32'(if_s.result), 32'd0);
    chk("reset done", 32'(if_s.done), 32'd0);
    chk("reset busy", 32'(if_s.busy), 32'd0);
    chk("reset ovf", 32'(if_s.ovf), 32'd0);
    chk("reset dz", 32'(if_s.dz), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_cancel", 2'b00, 24'h00C000, 24'h80C000, 24'h0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000);
    run_op("mul_ovf", 2'b10, 24'h4B0000, 24'h008000, 24'h0, 1'b0, 1'b0, 1'b1, 24'h7FFFFF, 24'h160000);
    run_op("div_7_2", 2'b11, 24'h01C000, 24'h008000, 24'h0, 1'b0, 1'b0, 1'b1, 24'h00E000, 24'h00E000);
    run_op("div_m7_2", 2'b11, 24'h81C000, 24'h008000, 24'h0, 1'b0, 1'b0, 1'b1, 24'h80E000, 24'h80E000);
    run_op("div_by_m0", 2'b11, 24'h004000, 24'h800000, 24'h0, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
    run_op("div_poke", 2'b11, 24'h01C000, 24'h008000, 24'h0, 1'b0, 1'b1, 1'b1, 24'h00E000, 24'h00E000);
    run_op("sub_imm", 2'b01, 24'h80A000, 24'h7FFFFF, 24'h004000, 1'b1, 1'b0, 1'b1, 24'h80E000, 24'h80E000);

    drive(1'b1, 2'b11, 24'h01C000, 24'h008000, 24'h0, 1'b0);
    @(posedge clk); #1;
    drive_junk(1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid busy", 32'(if_s.busy), 32'd0);
    chk("rst_mid result", 32'(if_s.result), 32'd0);
    chk("rst_mid flags", 32'({if_s.ovf, if_s.dz, if_s.done}), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if_s.done || if_w.done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (N + 5) begin
      @(posedge clk); #1;
      if (if_s.done || if_w.done) saw_done = 1'b1;
    end
    chk("rst_mid no_done", 32'(saw_done), 32'd0);
    run_op("add_after_rst", 2'b00, 24'h004000, 24'h004000, 24'h0, 1'b0, 1'b0, 1'b1, 24'h008000, 24'h008000);

    for (int k = 0; k < 40; k++) begin
      run_op("random", 2'($urandom_range(0, 3)), rnd_word(), rnd_word(), rnd_word(),
             1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
